// File: rtl/toeplitz_pkg.sv
// Shared definitions for the Toeplitz extractor output path: defaults, sizing helpers
// and the serializer state type.
package toeplitz_pkg;

  localparam int DEF_BS    = 64;
  localparam int DEF_N     = 256;
  localparam int DEF_L     = 128;
  localparam int DEF_W     = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_DCW   = 16;

  localparam int NCHUNK    = DEF_L / DEF_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  function automatic int nchunk(input int l, input int w);
    return l / w;
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/toeplitz_word_serializer_if.sv
// Word-in / chunk-stream-out bundle of the Toeplitz word serializer, plus its status.
interface toeplitz_word_serializer_if
  import toeplitz_pkg::*;
#(
  parameter int L     = DEF_L,
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int DCW   = DEF_DCW
);
  localparam int LVW = level_w(DEPTH);

  logic [L-1:0]   q_in;
  logic           qstrobe_in;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic           dout_last;
  logic           dout_ready;
  logic [LVW-1:0] level;
  logic           overflow;
  logic [DCW-1:0] drop_cnt;

  modport master (
    input  q_in, qstrobe_in, dout_ready,
    output dout, dout_valid, dout_last, level, overflow, drop_cnt
  );

  modport slave (
    output q_in, qstrobe_in, dout_ready,
    input  dout, dout_valid, dout_last, level, overflow, drop_cnt
  );

endinterface

// File: rtl/toeplitz_word_fifo.sv
// Single-clock register-array FIFO of L-bit words; occupancy comes from an explicit count.
module toeplitz_word_fifo
  import toeplitz_pkg::*;
#(
  parameter int L     = DEF_L,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [L-1:0]             din,
  output logic                     full,
  input  logic                     pop,
  output logic [L-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [L-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          wr;
  logic          rd;

  assign full  = (cnt == CNT_FULL);
  assign empty = (cnt == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rptr];
  assign level = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

endmodule

// File: rtl/toeplitz_word_serializer.sv
// Buffers extracted L-bit words and streams them LSB-first as W-bit chunks over valid/ready,
// counting words dropped when the buffer is full.
module toeplitz_word_serializer
  import toeplitz_pkg::*;
#(
  parameter int L     = DEF_L,
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int DCW   = DEF_DCW
) (
  input  logic                          clk,
  input  logic                          reset,
  toeplitz_word_serializer_if.master    bus
);
  localparam int NCH = nchunk(L, W);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LVW = level_w(DEPTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);

  generate
    if (L % W != 0) begin : g_bad_width
      $fatal(1, "toeplitz_word_serializer: L must be a multiple of W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "toeplitz_word_serializer: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  function automatic logic [DCW-1:0] sat_inc(input logic [DCW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ser_state_t     state;
  ser_state_t     state_nxt;
  logic [L-1:0]   sreg;
  logic [IW-1:0]  idx;
  logic           last_r;
  logic           load;
  logic           beat;
  logic           fifo_full;
  logic           fifo_empty;
  logic [L-1:0]   head;
  logic [LVW-1:0] fifo_level;
  logic           ovf;
  logic [DCW-1:0] dcnt;

  toeplitz_word_fifo #(.L(L), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.qstrobe_in),
    .din   (bus.q_in),
    .full  (fifo_full),
    .pop   (load),
    .dout  (head),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign beat = (state == SEND) && bus.dout_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Reloading on the final beat keeps the stream gap-free between words.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (beat && last_r) begin
          if (!fifo_empty) load = 1'b1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg   <= '0;
      idx    <= '0;
      last_r <= 1'b0;
    end else if (load) begin
      sreg   <= head;
      idx    <= '0;
      last_r <= (NCH == 1);
    end else if (beat) begin
      sreg   <= sreg >> W;
      idx    <= idx + 1'b1;
      last_r <= ((idx + 1'b1) == IDX_LAST);
    end
  end

  // Fullness is judged on the pre-edge count, so a same-cycle pop never saves the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf  <= 1'b0;
      dcnt <= '0;
    end else if (bus.qstrobe_in && fifo_full) begin
      ovf  <= 1'b1;
      dcnt <= sat_inc(dcnt);
    end
  end

  always_comb begin
    bus.dout       = sreg[W-1:0];
    bus.dout_valid = (state == SEND);
    bus.dout_last  = (state == SEND) && last_r;
    bus.level      = fifo_level;
    bus.overflow   = ovf;
    bus.drop_cnt   = dcnt;
  end

endmodule
